flag_slideshow_ctrl: RTL
========================

Name: flag_slideshow_ctrl

Overview:
- Sequencer that steps the VGA output through the flag set.
- Drives two flag-select indices (current, next) into two copies of the flag mux.
- Times the hold on each flag in frames and performs a left-to-right wipe transition.
- Handles debounced-by-edge user buttons for next, previous and pause.
- Sits between the hvsync generator and the top-level RGB222 output register.

Parameters:
- NUM_FLAGS, 16, number of selectable flags; indices 0..NUM_FLAGS-1; must be ≤ 2^SEL_W.
- SEL_W, 4, width of flag index outputs.
- HOLD_FRAMES, 180, frames a flag is held before auto-advance (1..255).
- WIPE_STEP, 16, wipe boundary advance in pixels per frame (1..639).
- H_ACTIVE, 640, active line width in pixels.

Ports:
- clk, input, 1, pixel clock.
- rst, input, 1, reset; asynchronous, active-high.
- vsync, input, 1, active-high vertical sync from hvsync generator, same clock domain.
- pix_x, input, 10, current pixel column.
- auto_en, input, 1, level; 1 = timed auto-advance enabled.
- btn_next, input, 1, asynchronous pushbutton, active-high.
- btn_prev, input, 1, asynchronous pushbutton, active-high.
- btn_pause, input, 1, asynchronous pushbutton, active-high; toggles pause.
- cur_color, input, 6, RGB222 from flag mux driven by cur_sel.
- nxt_color, input, 6, RGB222 from flag mux driven by nxt_sel.
- cur_sel, output, SEL_W, index of displayed flag.
- nxt_sel, output, SEL_W, index of incoming flag.
- color, output, 6, RGB222 pixel to output stage.
- busy, output, 1, 1 while a wipe is in progress.
- paused, output, 1, pause state.

Behaviour:
- Reset (async): state=HOLD, cur_sel=0, nxt_sel=0, frame_cnt=0, wipe_pos=0, paused=0, busy=0, sync/edge flops=0.
- Frame tick: single-cycle pulse on vsync rising edge, via a registered previous-vsync flop. No synchronizer on vsync.
- Buttons: each through a 2-FF synchronizer, then a rising-edge detect. One edge gives one pulse; held buttons do not repeat. Input-to-pulse latency is 3 clk.
- btn_pause pulse toggles paused in any state. Pause freezes frame_cnt only. Manual next/prev still work and an active wipe completes.
- State HOLD, busy=0:
  - Tick with auto_en=1 and paused=0: frame_cnt++.
  - Tick with frame_cnt==HOLD_FRAMES-1: start forward wipe.
  - Next pulse: start forward wipe in the same cycle, independent of auto_en and paused.
  - Prev pulse: start backward wipe.
  - Next and prev in the same cycle: next wins.
  - A manual pulse coinciding with auto expiry produces exactly one wipe, using the manual direction.
- Start wipe:
  - nxt_sel = cur_sel+1, wrapping NUM_FLAGS-1→0 (forward); or cur_sel-1, wrapping 0→NUM_FLAGS-1 (backward).
  - wipe_pos=0, frame_cnt=0, state=WIPE.
- State WIPE, busy=1:
  - Next/prev pulses are ignored (dropped, not queued).
  - On tick: if wipe_pos+WIPE_STEP ≥ H_ACTIVE, then cur_sel=nxt_sel, wipe_pos=0, frame_cnt=0, state=HOLD. Otherwise wipe_pos += WIPE_STEP.
  - Compute the compare in 11 bits; no wrap.
- Pixel mux, combinational, zero latency relative to pix_x: color = nxt_color if state==WIPE and pix_x < wipe_pos, else cur_color.
  - The boundary only moves on ticks, i.e. during vertical blanking, so no tearing.
- nxt_sel keeps its last value in HOLD and must remain stable for the whole wipe.
- A first-frame wipe shows 0 px of the new flag. Wipe length is ceil(H_ACTIVE/WIPE_STEP) frames: 40 at defaults.
- Reset mid-wipe returns immediately to flag 0 in HOLD with no wipe.

Test Plan:
- Reset, HOLD_FRAMES=4, auto_en=1, 4 ticks → wipe starts: cur_sel=0, nxt_sel=1, busy=1. WIPE_STEP=320 → after 2 more ticks cur_sel=1, busy=0.
- Backward wrap: cur_sel=0, btn_prev pulse → nxt_sel=15. After wipe completes, cur_sel=15. Forward from 15 → nxt_sel=0.
- Pixel mux during WIPE with wipe_pos=320, cur_color=6'h03, nxt_color=6'h30:
  - pix_x=319 → color=6'h30.
  - pix_x=320 → color=6'h03.
  - In HOLD, any pix_x → 6'h03.
- Pause: btn_pause pulse → paused=1; 10 ticks → no wipe, frame_cnt unchanged. btn_next still starts a wipe. Second pause pulse → paused=0 and counting resumes.
- Contention cases:
  - btn_next and btn_prev in the same cycle → forward wipe.
  - btn_next pressed during WIPE → ignored, cur_sel advances only once.
  - btn_next held for 100 frames → exactly one wipe.
- Async rst asserted mid-wipe, between clock edges → outputs go to reset values immediately: cur_sel=0, busy=0, color=cur_color.

Source files
------------

// File: rtl/flag_slideshow_ctrl.sv
// Flag slideshow sequencer: picks current/next flag, holds each for HOLD_FRAMES, wipes left-to-right.
// Buttons are synchronized and edge-detected; the pixel mux is combinational on pix_x.
module flag_slideshow_ctrl #(
    parameter int NUM_FLAGS   = 16,
    parameter int SEL_W       = 4,
    parameter int HOLD_FRAMES = 180,
    parameter int WIPE_STEP   = 16,
    parameter int H_ACTIVE    = 640
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic [9:0]       pix_x,
    input  logic             auto_en,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic             btn_pause,
    input  logic [5:0]       cur_color,
    input  logic [5:0]       nxt_color,
    output logic [SEL_W-1:0] cur_sel,
    output logic [SEL_W-1:0] nxt_sel,
    output logic [5:0]       color,
    output logic             busy,
    output logic             paused
);

    localparam int POS_W = 11;

    typedef enum logic {
        S_HOLD = 1'b0,
        S_WIPE = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]   nxt_sel_q, nxt_sel_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
    logic [POS_W-1:0]   wipe_pos_q, wipe_pos_d;
    logic               paused_q, paused_d;
    logic               vsync_prev_q, vsync_prev_d;

    // Button bit order: [0]=next, [1]=prev, [2]=pause
    logic [2:0]         sync1_q, sync1_d;
    logic [2:0]         sync2_q, sync2_d;
    logic [2:0]         sync3_q, sync3_d;
    logic [2:0]         pulse_q, pulse_d;

    logic               tick;
    logic               next_pulse;
    logic               prev_pulse;
    logic               pause_pulse;
    logic               start_fwd;
    logic               start_bwd;
    logic [POS_W-1:0]   wipe_sum;
    logic [SEL_W-1:0]   fwd_sel;
    logic [SEL_W-1:0]   bwd_sel;

    always_comb begin
        sync1_d      = {btn_pause, btn_prev, btn_next};
        sync2_d      = sync1_q;
        sync3_d      = sync2_q;
        pulse_d      = sync2_q & ~sync3_q;
        vsync_prev_d = vsync;
    end

    assign tick        = vsync & ~vsync_prev_q;
    assign next_pulse  = pulse_q[0];
    assign prev_pulse  = pulse_q[1];
    assign pause_pulse = pulse_q[2];

    // 11-bit sum so the last step past H_ACTIVE cannot wrap.
    assign wipe_sum = wipe_pos_q + POS_W'(WIPE_STEP);
    assign fwd_sel  = (cur_sel_q == SEL_W'(NUM_FLAGS - 1)) ? '0 : cur_sel_q + SEL_W'(1);
    assign bwd_sel  = (cur_sel_q == '0) ? SEL_W'(NUM_FLAGS - 1) : cur_sel_q - SEL_W'(1);

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        nxt_sel_d   = nxt_sel_q;
        frame_cnt_d = frame_cnt_q;
        wipe_pos_d  = wipe_pos_q;
        paused_d    = paused_q ^ pause_pulse;
        start_fwd   = 1'b0;
        start_bwd   = 1'b0;

        case (state_q)
            S_HOLD: begin
                // Manual buttons take priority over the auto timer, next over prev.
                if (next_pulse) begin
                    start_fwd = 1'b1;
                end else if (prev_pulse) begin
                    start_bwd = 1'b1;
                end else if (tick && auto_en && !paused_q) begin
                    if (frame_cnt_q == 8'(HOLD_FRAMES - 1)) begin
                        start_fwd = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
            end
            S_WIPE: begin
                if (tick) begin
                    if (wipe_sum >= POS_W'(H_ACTIVE)) begin
                        cur_sel_d   = nxt_sel_q;
                        wipe_pos_d  = '0;
                        frame_cnt_d = '0;
                        state_d     = S_HOLD;
                    end else begin
                        wipe_pos_d  = wipe_sum;
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase

        if (start_fwd || start_bwd) begin
            nxt_sel_d   = start_fwd ? fwd_sel : bwd_sel;
            wipe_pos_d  = '0;
            frame_cnt_d = '0;
            state_d     = S_WIPE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HOLD;
            cur_sel_q    <= '0;
            nxt_sel_q    <= '0;
            frame_cnt_q  <= '0;
            wipe_pos_q   <= '0;
            paused_q     <= 1'b0;
            vsync_prev_q <= 1'b0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            pulse_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_sel_q    <= cur_sel_d;
            nxt_sel_q    <= nxt_sel_d;
            frame_cnt_q  <= frame_cnt_d;
            wipe_pos_q   <= wipe_pos_d;
            paused_q     <= paused_d;
            vsync_prev_q <= vsync_prev_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            pulse_q      <= pulse_d;
        end
    end

    // Boundary only moves on vsync ticks, so the split is tear-free.
    always_comb begin
        color = cur_color;
        if (state_q == S_WIPE && ({1'b0, pix_x} < wipe_pos_q)) begin
            color = nxt_color;
        end
    end

    assign cur_sel = cur_sel_q;
    assign nxt_sel = nxt_sel_q;
    assign busy    = (state_q == S_WIPE);
    assign paused  = paused_q;

endmodule
